// File: rtl/fetch_redirect_ctrl_if.sv
// Redirect/fetch bus between the front-end pipeline and fetch_redirect_ctrl.
// The master drives the redirect requests and the IF1 view. The slave
// (the controller) returns the next fetch address and the flush/telemetry signals.
interface fetch_redirect_ctrl_if;
   logic        ex_taken;
   logic        eret_taken;
   logic [31:0] epc;
   logic        br_prd_err;
   logic [31:0] br_target;
   logic        bp_valid;
   logic [31:0] bp_target;
   logic [31:0] f1s_pc;
   logic        f1s_allowin;
   logic [31:0] nextpc;
   logic [2:0]  redirect_kind;
   logic        redirect_fire;
   logic        fetch_flush;
   logic [7:0]  hold_cycles;

   modport master (
      output ex_taken, eret_taken, epc, br_prd_err, br_target, bp_valid, bp_target,
             f1s_pc, f1s_allowin,
      input  nextpc, redirect_kind, redirect_fire, fetch_flush, hold_cycles
   );

   modport slave (
      input  ex_taken, eret_taken, epc, br_prd_err, br_target, bp_valid, bp_target,
             f1s_pc, f1s_allowin,
      output nextpc, redirect_kind, redirect_fire, fetch_flush, hold_cycles
   );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Next-PC selection for IF1. Live redirects win by priority (ex > eret > br > bp > seq).
// A redirect that IF1 cannot accept yet is parked in pending registers (HOLD)
// until f1s_allowin. Only a strictly higher-priority live event may replace it.
module fetch_redirect_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'hbfc00000,
   parameter logic [31:0] EX_VECTOR = 32'hbfc00380
) (
   input logic                  clk,
   input logic                  resetn,
   fetch_redirect_ctrl_if.slave bus
);

   // Kind codes double as priority: a larger value wins (boot is never compared).
   localparam logic [2:0] KindSeq  = 3'd0;
   localparam logic [2:0] KindBp   = 3'd1;
   localparam logic [2:0] KindBr   = 3'd2;
   localparam logic [2:0] KindEret = 3'd3;
   localparam logic [2:0] KindEx   = 3'd4;
   localparam logic [2:0] KindBoot = 3'd5;

   typedef enum logic [1:0] {StBoot = 2'd0, StRun = 2'd1, StHold = 2'd2} state_e;

   state_e      state_q, state_d;
   logic [2:0]  pend_kind_q, pend_kind_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;
   logic [7:0]  hold_cnt_q, hold_cnt_d;

   logic [2:0]  live_kind;
   logic [31:0] live_tgt;
   logic [2:0]  kind;
   logic [31:0] npc;

   // Highest-priority live redirect request this cycle.
   always_comb begin
      live_kind = KindSeq;
      live_tgt  = bus.f1s_pc + 32'd4;
      if (bus.ex_taken) begin
         live_kind = KindEx;
         live_tgt  = EX_VECTOR;
      end else if (bus.eret_taken) begin
         live_kind = KindEret;
         live_tgt  = bus.epc;
      end else if (bus.br_prd_err) begin
         live_kind = KindBr;
         live_tgt  = bus.br_target;
      end else if (bus.bp_valid) begin
         live_kind = KindBp;
         live_tgt  = bus.bp_target;
      end
   end

   // Next-state and next-PC selection.
   always_comb begin
      state_d     = state_q;
      pend_kind_d = pend_kind_q;
      pend_tgt_d  = pend_tgt_q;
      hold_cnt_d  = hold_cnt_q;
      kind        = KindSeq;
      npc         = bus.f1s_pc + 32'd4;
      unique case (state_q)
         StBoot: begin
            kind = KindBoot;
            npc  = RESET_PC;
            if (bus.f1s_allowin) state_d = StRun;
         end
         StRun: begin
            kind = live_kind;
            npc  = live_tgt;
            if (live_kind != KindSeq && !bus.f1s_allowin) begin
               state_d     = StHold;
               pend_kind_d = live_kind;
               pend_tgt_d  = live_tgt;
               hold_cnt_d  = 8'd0;
            end
         end
         StHold: begin
            kind = pend_kind_q;
            npc  = pend_tgt_q;
            if (live_kind > pend_kind_q) begin
               kind        = live_kind;
               npc         = live_tgt;
               pend_kind_d = live_kind;
               pend_tgt_d  = live_tgt;
            end
            if (hold_cnt_q != 8'hff) hold_cnt_d = hold_cnt_q + 8'd1;
            // Pending is cleared on release so it never leaks into RUN's flush term.
            if (bus.f1s_allowin) begin
               state_d     = StRun;
               pend_kind_d = KindSeq;
               pend_tgt_d  = 32'd0;
            end
         end
         default: begin
            state_d = StBoot;
         end
      endcase
   end

   // State, pending redirect and hold counter registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= StBoot;
         pend_kind_q <= KindSeq;
         pend_tgt_q  <= 32'd0;
         hold_cnt_q  <= 8'd0;
      end else begin
         state_q     <= state_d;
         pend_kind_q <= pend_kind_d;
         pend_tgt_q  <= pend_tgt_d;
         hold_cnt_q  <= hold_cnt_d;
      end
   end

   assign bus.nextpc        = npc;
   assign bus.redirect_kind = kind;
   assign bus.hold_cycles   = hold_cnt_q;
   // Gated by resetn so fire/flush stay low while reset is held, whatever the inputs do.
   assign bus.redirect_fire = resetn & bus.f1s_allowin & (kind != KindSeq);
   assign bus.fetch_flush   = resetn & ((live_kind >= KindBr) | (pend_kind_q >= KindBr));

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios with literal expectations,
// then randomized traffic. A behavioural model is compared against the DUT on every cycle.
module tb_fetch_redirect_ctrl;
   localparam logic [31:0] RPC = 32'hbfc00000;
   localparam logic [31:0] EXV = 32'hbfc00380;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   total = 0;
   int   bad = 0;
   bit   chk_en = 1'b0;

   always #5 clk = ~clk;

   fetch_redirect_ctrl_if bus();

   fetch_redirect_ctrl #(.RESET_PC(RPC), .EX_VECTOR(EXV)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   // Model state: mode 0 boot, 1 run, 2 hold. pk/pt is the parked redirect.
   int          m_mode;
   int          m_pk;
   logic [31:0] m_pt;
   int          m_hc;

   function automatic int lv_kind();
      int k = 0;
      if (bus.bp_valid)   k = 1;
      if (bus.br_prd_err) k = 2;
      if (bus.eret_taken) k = 3;
      if (bus.ex_taken)   k = 4;
      return k;
   endfunction

   function automatic logic [31:0] lv_tgt(int k);
      case (k)
         4:       return EXV;
         3:       return bus.epc;
         2:       return bus.br_target;
         1:       return bus.bp_target;
         default: return bus.f1s_pc + 32'd4;
      endcase
   endfunction

   // Model update on each clock edge; reset wipes everything at once.
   always @(posedge clk or negedge resetn) begin
      int lk;
      if (!resetn) begin
         m_mode = 0; m_pk = 0; m_pt = 0; m_hc = 0;
      end else begin
         lk = lv_kind();
         if (m_mode == 0) begin
            if (bus.f1s_allowin) m_mode = 1;
         end else if (m_mode == 1) begin
            if (lk != 0 && !bus.f1s_allowin) begin
               m_mode = 2; m_pk = lk; m_pt = lv_tgt(lk); m_hc = 0;
            end
         end else begin
            m_hc = (m_hc < 255) ? m_hc + 1 : 255;
            if (lk > m_pk) begin m_pk = lk; m_pt = lv_tgt(lk); end
            if (bus.f1s_allowin) begin m_mode = 1; m_pk = 0; end
         end
      end
   end

   task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      int          lk, ek;
      logic [31:0] epcv;
      bit          efl;
      if (chk_en) begin
         lk = lv_kind();
         if (!resetn) begin
            ek = 5; epcv = RPC;
         end else if (m_mode == 0) begin
            ek = 5; epcv = RPC;
         end else if (m_mode == 1) begin
            ek = lk; epcv = lv_tgt(lk);
         end else if (lk > m_pk) begin
            ek = lk; epcv = lv_tgt(lk);
         end else begin
            ek = m_pk; epcv = m_pt;
         end
         efl = resetn && (lk >= 2 || (m_mode == 2 && m_pk >= 2));
         cmp("m_nextpc", bus.nextpc, epcv);
         cmp("m_kind", {29'd0, bus.redirect_kind}, ek);
         cmp("m_fire", {31'd0, bus.redirect_fire}, {31'd0, resetn && bus.f1s_allowin && ek != 0});
         cmp("m_flush", {31'd0, bus.fetch_flush}, {31'd0, efl});
         cmp("m_hold", {24'd0, bus.hold_cycles}, m_hc);
      end
   end

   // One cycle of stimulus, applied just after the edge; literal checks follow at +3.
   task automatic step(bit rst, bit allow, logic [31:0] pc, bit ex, bit er, logic [31:0] ep,
                       bit br, logic [31:0] brt, bit bp, logic [31:0] bpt);
      @(posedge clk);
      #1;
      resetn = rst;
      bus.f1s_allowin = allow; bus.f1s_pc = pc;
      bus.ex_taken = ex; bus.eret_taken = er; bus.epc = ep;
      bus.br_prd_err = br; bus.br_target = brt;
      bus.bp_valid = bp; bus.bp_target = bpt;
      #2;
   endtask

   task automatic idle(bit allow, logic [31:0] pc);
      step(1'b1, allow, pc, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      bus.ex_taken = 0; bus.eret_taken = 0; bus.epc = 0; bus.br_prd_err = 0;
      bus.br_target = 0; bus.bp_valid = 0; bus.bp_target = 0; bus.f1s_pc = 0;
      bus.f1s_allowin = 1;
      chk_en = 1'b1;

      // Held in reset with allowin high: boot values, no fire.
      step(1'b0, 1, 32'h0, 1, 0, 0, 1, 32'h1, 0, 0);
      cmp("rst_npc", bus.nextpc, 32'hbfc00000);
      cmp("rst_kind", {29'd0, bus.redirect_kind}, 32'd5);
      cmp("rst_fire", {31'd0, bus.redirect_fire}, 32'd0);
      cmp("rst_flush", {31'd0, bus.fetch_flush}, 32'd0);

      // Boot cycle then first sequential fetch.
      idle(1, 32'h0);
      cmp("boot_npc", bus.nextpc, 32'hbfc00000);
      cmp("boot_fire", {31'd0, bus.redirect_fire}, 32'd1);
      idle(1, 32'hbfc00000);
      cmp("seq_npc", bus.nextpc, 32'hbfc00004);
      cmp("seq_kind", {29'd0, bus.redirect_kind}, 32'd0);

      // Mispredict held for three cycles, released on the fourth.
      step(1, 0, 32'h80001000, 0, 0, 0, 1, 32'h80002000, 0, 0);
      cmp("br_npc0", bus.nextpc, 32'h80002000);
      cmp("br_flush0", {31'd0, bus.fetch_flush}, 32'd1);
      for (int i = 0; i < 2; i++) begin
         idle(0, 32'h80001000);
         cmp("br_npc_hold", bus.nextpc, 32'h80002000);
         cmp("br_flush_hold", {31'd0, bus.fetch_flush}, 32'd1);
      end
      idle(1, 32'h80001000);
      cmp("br_npc_rel", bus.nextpc, 32'h80002000);
      cmp("br_fire_rel", {31'd0, bus.redirect_fire}, 32'd1);
      idle(1, 32'h80002000);
      cmp("br_holdcnt", {24'd0, bus.hold_cycles}, 32'd3);

      // Exception overrides a parked br; a later eret is ignored.
      step(1, 0, 32'h80002000, 0, 0, 0, 1, 32'h80002000, 0, 0);
      step(1, 0, 32'h80002000, 1, 0, 0, 0, 0, 0, 0);
      cmp("ex_npc", bus.nextpc, 32'hbfc00380);
      cmp("ex_kind", {29'd0, bus.redirect_kind}, 32'd4);
      step(1, 0, 32'h80002000, 0, 1, 32'h12345678, 0, 0, 0, 0);
      cmp("ex_keep", bus.nextpc, 32'hbfc00380);
      idle(1, 32'h80002000);
      cmp("ex_rel", bus.nextpc, 32'hbfc00380);

      // Simultaneous eret/br/bp with allowin: eret wins, consumed in RUN.
      step(1, 1, 32'hbfc00380, 0, 1, 32'h80000100, 1, 32'h80009000, 1, 32'h8000a000);
      cmp("pri_npc", bus.nextpc, 32'h80000100);
      cmp("pri_kind", {29'd0, bus.redirect_kind}, 32'd3);
      idle(1, 32'h80000100);
      cmp("pri_run", bus.nextpc, 32'h80000104);

      // Wraparound and bp-only no-flush.
      idle(1, 32'hfffffffc);
      cmp("wrap_npc", bus.nextpc, 32'h00000000);
      step(1, 1, 32'h00000000, 0, 0, 0, 0, 0, 1, 32'h00004000);
      cmp("bp_flush", {31'd0, bus.fetch_flush}, 32'd0);
      cmp("bp_npc", bus.nextpc, 32'h00004000);

      // Long hold saturates the counter; reset mid-hold discards it.
      step(1, 0, 32'h00004000, 0, 0, 0, 1, 32'h00008000, 0, 0);
      for (int i = 0; i < 300; i++) idle(0, 32'h00004000);
      cmp("sat_hold", {24'd0, bus.hold_cycles}, 32'd255);
      step(1'b0, 0, 32'h00004000, 0, 0, 0, 0, 0, 0, 0);
      cmp("rstmid_npc", bus.nextpc, 32'hbfc00000);
      cmp("rstmid_flush", {31'd0, bus.fetch_flush}, 32'd0);
      idle(0, 32'h0);
      cmp("rstmid_boot", {29'd0, bus.redirect_kind}, 32'd5);
      idle(1, 32'h0);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         logic [31:0] pc;
         pc = ($urandom_range(0, 15) == 0) ? 32'hfffffffc : $urandom;
         step(($urandom_range(0, 299) != 0), ($urandom_range(0, 2) == 0), pc,
              ($urandom_range(0, 19) == 0), ($urandom_range(0, 14) == 0), $urandom,
              ($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 5) == 0), $urandom);
      end

      @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_redirect_ctrl.md
FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hbfc00000, the first fetch address after reset.
REQ-002 SHALL have parameter EX_VECTOR, default 32'hbfc00380, the exception entry address.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ex_taken  input  1  exception redirect request, 1-cycle pulse.
REQ-006 SHALL have port eret_taken  input  1  ERET redirect request, 1-cycle pulse.
REQ-007 SHALL have port epc  input  32  ERET target, valid with eret_taken.
REQ-008 SHALL have port br_prd_err  input  1  branch mispredict pulse.
REQ-009 SHALL have port br_target  input  32  corrected target, valid with br_prd_err.
REQ-010 SHALL have port bp_valid  input  1  predicted redirect after a delay slot.
REQ-011 SHALL have port bp_target  input  32  predicted target, valid with bp_valid.
REQ-012 SHALL have port f1s_pc  input  32  PC currently held in IF1.
REQ-013 SHALL have port f1s_allowin  input  1  IF1 loads nextpc this cycle.
REQ-014 SHALL have port nextpc  output  32  address IF1 loads when f1s_allowin=1.
REQ-015 SHALL have port redirect_kind  output  3  source of nextpc: 0 seq, 1 bp, 2 br, 3 eret, 4 ex, 5 boot.
REQ-016 SHALL have port redirect_fire  output  1  a non-sequential nextpc is consumed this cycle.
REQ-017 SHALL have port fetch_flush  output  1  kill younger in-flight fetches (IF1/IF2).
REQ-018 SHALL have port hold_cycles  output  8  count of cycles spent in HOLD, saturating.

Function
REQ-019 SHALL implement states BOOT, RUN and HOLD; the state register is 2 bits.
REQ-020 BOOT SHALL drive nextpc=RESET_PC and kind=5, and SHALL go to RUN on the first cycle with f1s_allowin=1.
REQ-021 Live priority SHALL be ex > eret > br_prd_err > bp_valid > sequential; sequential nextpc = f1s_pc + 4, computed mod 2^32.
REQ-022 In RUN with no event, nextpc SHALL be the sequential value and kind=0.
REQ-023 In RUN, the highest live event SHALL drive nextpc combinationally in the same cycle (EX_VECTOR, epc, br_target or bp_target).
REQ-024 In RUN, an event with f1s_allowin=1 SHALL be consumed that cycle and the state SHALL stay RUN.
REQ-025 In RUN, an event with f1s_allowin=0 SHALL latch its kind and target into pending registers and the state SHALL go to HOLD.
REQ-026 In HOLD, nextpc and kind SHALL come from the pending registers unless a live event of strictly higher priority is present; that event SHALL then drive the outputs and overwrite the pending registers.
REQ-027 In HOLD, a live event of equal or lower priority SHALL be ignored, so the first captured target is retained.
REQ-028 In HOLD with f1s_allowin=1, the redirect SHALL be consumed and the state SHALL go to RUN.
REQ-029 If a strictly higher-priority live event coincides with f1s_allowin=1 in HOLD, the live event SHALL be consumed.
REQ-030 redirect_fire SHALL equal f1s_allowin AND (kind is not 0).
REQ-031 fetch_flush SHALL be 1 in any cycle with a live ex, eret or br_prd_err event, or a pending kind of 2, 3 or 4; a bp event alone SHALL NOT assert it.
REQ-032 hold_cycles SHALL clear on each RUN->HOLD transition, increment by 1 per cycle spent in HOLD, and saturate at 255.
REQ-033 Outputs SHALL depend combinationally only on the current inputs and registered state; there SHALL be no other added latency.

Reset
REQ-034 While resetn=0: state=BOOT, pending registers=0, hold_cycles=0, nextpc=RESET_PC, redirect_kind=5, redirect_fire=0, fetch_flush=0.
REQ-035 Assertion of resetn in any state, including mid-HOLD, SHALL discard pending redirects immediately.
REQ-036 Reset deassertion SHALL take effect synchronously at the next clock edge.

Verification
REQ-037 Reset release, f1s_allowin=1 -> nextpc=bfc00000 with kind=5 for one cycle; next cycle nextpc=bfc00004 with kind=0.
REQ-038 RUN, f1s_pc=80001000, br_prd_err with br_target=80002000, f1s_allowin=0 for 3 cycles then 1 -> nextpc=80002000 and fetch_flush=1 throughout, hold_cycles=3, redirect_fire=1 on the release cycle.
REQ-039 HOLD on br (target 80002000), then ex_taken arrives -> nextpc=bfc00380 with kind=4; a later eret_taken is ignored; release yields bfc00380.
REQ-040 Same cycle: eret_taken (epc=80000100), br_prd_err and bp_valid with f1s_allowin=1 -> nextpc=80000100, kind=3, state stays RUN.
REQ-041 f1s_pc=fffffffc, no events -> nextpc=00000000, kind=0; bp_valid alone -> fetch_flush=0.
REQ-042 HOLD held for 300 cycles -> hold_cycles=255; resetn pulse mid-HOLD -> state=BOOT, nextpc=bfc00000.
